fir_filter_ctrl: RTL and testbench

FIR_FILTER_CTRL -- requirements
Module: fir_filter_ctrl

---
 rtl/fir_filter_ctrl_if.sv | 37 +++
 rtl/fir_filter_ctrl.sv | 131 +++++++++++++
 tb/tb_fir_filter_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_ctrl_if.sv
// Bundles the controller's configuration, sample, result and core-side signals.
// Ports: cfg_* coefficient load handshake, in_* / out_* sample and result handshakes,
//        core_* strobes and data to/from the FIR core, sample_cnt and busy status.
interface fir_filter_ctrl_if;
  logic        cfg_start;
  logic        cfg_coeff_valid;
  logic [7:0]  cfg_coeff;
  logic        cfg_coeff_ready;
  logic        cfg_done;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        core_coeffs_shift;
  logic [7:0]  core_coeffs_in;
  logic        core_sample;
  logic [31:0] core_data_in;
  logic [31:0] core_data_out;
  logic [15:0] sample_cnt;
  logic        busy;

  // Environment side: offers coefficients and samples, consumes results, models the core.
  modport master (
    output cfg_start, cfg_coeff_valid, cfg_coeff, in_valid, in_data, out_ready, core_data_out,
    input  cfg_coeff_ready, cfg_done, in_ready, out_valid, out_data,
           core_coeffs_shift, core_coeffs_in, core_sample, core_data_in, sample_cnt, busy
  );

  // Controller side.
  modport slave (
    input  cfg_start, cfg_coeff_valid, cfg_coeff, in_valid, in_data, out_ready, core_data_out,
    output cfg_coeff_ready, cfg_done, in_ready, out_valid, out_data,
           core_coeffs_shift, core_coeffs_in, core_sample, core_data_in, sample_cnt, busy
  );
endinterface

// File: rtl/fir_filter_ctrl.sv
// Sequences coefficient loading and one-at-a-time sample processing for an attached FIR core.
// Ports: clk, rst (sync, active-high), bus (slave view of fir_filter_ctrl_if).
// A result is captured OUT_LAT cycles after its core_sample strobe and held until out_ready.
module fir_filter_ctrl #(
  parameter int LENGTH  = 20,
  parameter int OUT_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  fir_filter_ctrl_if.slave bus
);

  localparam int TW = $clog2(LENGTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, OUT} state_t;

  state_t        state;
  logic [TW-1:0] tap_cnt;
  logic [3:0]    lat_cnt;
  logic [15:0]   sample_cnt;
  logic [31:0]   out_data;
  logic          coeff_ready;
  logic          in_ready;
  logic          out_valid;
  logic          cfg_done;
  logic          busy;

  logic coeff_hs;
  logic sample_hs;

  // Readies are only ever high in LOAD / RUN, so the strobes are confined to those states
  // and can never coincide.
  assign coeff_hs  = bus.cfg_coeff_valid && coeff_ready;
  assign sample_hs = bus.in_valid && in_ready;

  assign bus.core_coeffs_shift = coeff_hs;
  assign bus.core_coeffs_in    = coeff_hs ? bus.cfg_coeff : 8'd0;
  assign bus.core_sample       = sample_hs;
  assign bus.core_data_in      = sample_hs ? bus.in_data : 32'd0;

  assign bus.cfg_coeff_ready = coeff_ready;
  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid;
  assign bus.out_data        = out_data;
  assign bus.cfg_done        = cfg_done;
  assign bus.busy            = busy;
  assign bus.sample_cnt      = sample_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tap_cnt     <= '0;
      lat_cnt     <= '0;
      sample_cnt  <= '0;
      out_data    <= '0;
      coeff_ready <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      cfg_done    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            state       <= LOAD;
            tap_cnt     <= '0;
            sample_cnt  <= '0;
            coeff_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (coeff_hs) begin
            tap_cnt <= tap_cnt + 1'b1;
            if (tap_cnt == TW'(LENGTH - 1)) begin
              state       <= RUN;
              coeff_ready <= 1'b0;
              in_ready    <= 1'b1;
              busy        <= 1'b0;
              cfg_done    <= 1'b1;
            end
          end
        end
        RUN: begin
          // A sample in the same cycle as cfg_start takes priority; the reload request is lost.
          if (sample_hs) begin
            state    <= WAIT;
            lat_cnt  <= 4'(OUT_LAT);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
          end else if (bus.cfg_start) begin
            state       <= LOAD;
            tap_cnt     <= '0;
            sample_cnt  <= '0;
            in_ready    <= 1'b0;
            coeff_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        WAIT: begin
          // The cycle that would take the counter to zero is OUT_LAT cycles after the strobe.
          if (lat_cnt <= 4'd1) begin
            lat_cnt   <= '0;
            out_data  <= bus.core_data_out;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= RUN;
          end
        end
        default: begin
          state       <= IDLE;
          coeff_ready <= 1'b0;
          in_ready    <= 1'b0;
          out_valid   <= 1'b0;
          busy        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_ctrl.sv
// Directed bench for fir_filter_ctrl with LENGTH=4, OUT_LAT=2 and a behavioural FIR core.
// Inputs are driven and outputs sampled on the falling edge; the core registers its sum
// once, so core_data_out is valid two cycles after core_sample.
module tb_fir_filter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_filter_ctrl_if bus();

  fir_filter_ctrl #(.LENGTH(4), .OUT_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural 4-tap core: first coefficient shifted in ends up on the oldest sample.
  logic [7:0]  c [4];
  logic [31:0] x [4];
  logic [31:0] pipe;
  logic [31:0] sum;

  always_comb begin
    sum = 32'd0;
    for (int i = 0; i < 4; i++) sum = sum + {24'd0, c[i]} * x[i];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        c[i] <= 8'd0;
        x[i] <= 32'd0;
      end
      pipe <= 32'd0;
    end else begin
      if (bus.core_coeffs_shift) begin
        c[0] <= bus.core_coeffs_in;
        for (int i = 1; i < 4; i++) c[i] <= c[i-1];
      end
      if (bus.core_sample) begin
        x[0] <= bus.core_data_in;
        for (int i = 1; i < 4; i++) x[i] <= x[i-1];
      end
      pipe <= sum;
    end
  end

  assign bus.core_data_out = pipe;

  // Event counters over the whole run.
  int shift_pulses  = 0;
  int sample_pulses = 0;
  int both_pulses   = 0;
  always @(posedge clk) begin
    if (bus.core_coeffs_shift) shift_pulses <= shift_pulses + 1;
    if (bus.core_sample) sample_pulses <= sample_pulses + 1;
    if (bus.core_coeffs_shift && bus.core_sample) both_pulses <= both_pulses + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offers one sample in RUN and checks the full RUN->WAIT->OUT->RUN round trip.
  task automatic send_sample(input logic [31:0] d, input logic [31:0] exp);
    check("in_ready_run", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    check("core_sample_strobe", 32'(bus.core_sample), 32'd1);
    check("core_data_in", bus.core_data_in, d);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    check("out_valid_lat1", 32'(bus.out_valid), 32'd0);
    tick();
    check("out_valid_lat2", 32'(bus.out_valid), 32'd0);
    tick();
    check("out_valid_lat3", 32'(bus.out_valid), 32'd1);
    check("out_data", bus.out_data, exp);
    check("in_ready_out", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_cleared", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int base;
    logic [31:0] samp [5];
    logic [31:0] expv [5];
    samp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    expv = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0};

    bus.cfg_start       = 1'b0;
    bus.cfg_coeff_valid = 1'b0;
    bus.cfg_coeff       = 8'd0;
    bus.in_valid        = 1'b0;
    bus.in_data         = 32'd0;
    bus.out_ready       = 1'b0;

    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_coeff_ready", 32'(bus.cfg_coeff_ready), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
    check("rst_cfg_done", 32'(bus.cfg_done), 32'd0);
    rst = 1'b0;

    // IDLE ignores samples.
    bus.in_valid = 1'b1;
    #1;
    check("idle_no_sample", 32'(bus.core_sample), 32'd0);
    tick();
    bus.in_valid = 1'b0;

    // Reset in the middle of a coefficient load.
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("load_coeff_ready", 32'(bus.cfg_coeff_ready), 32'd1);
    base = shift_pulses;
    for (int k = 0; k < 2; k++) begin
      bus.cfg_coeff_valid = 1'b1;
      bus.cfg_coeff       = 8'(9 - k);
      #1;
      check("partial_shift", 32'(bus.core_coeffs_shift), 32'd1);
      check("partial_coeff_in", 32'(bus.core_coeffs_in), 32'(9 - k));
      tick();
    end
    bus.cfg_coeff_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midload_rst_ready", 32'(bus.cfg_coeff_ready), 32'd0);
    check("midload_rst_busy", 32'(bus.busy), 32'd1);
    bus.cfg_coeff_valid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    bus.cfg_coeff_valid = 1'b0;
    check("midload_shift_count", 32'(shift_pulses - base), 32'd2);

    // Full load of 1,2,3,4 back-to-back.
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("load_sample_cnt_clear", 32'(bus.sample_cnt), 32'd0);
    base = shift_pulses;
    for (int k = 1; k <= 4; k++) begin
      bus.cfg_coeff_valid = 1'b1;
      bus.cfg_coeff       = 8'(k);
      check("cfg_done_early", 32'(bus.cfg_done), 32'd0);
      tick();
    end
    bus.cfg_coeff_valid = 1'b0;
    bus.cfg_coeff       = 8'd0;
    #1;
    check("coeff_in_idle_zero", 32'(bus.core_coeffs_in), 32'd0);
    check("cfg_done_pulse", 32'(bus.cfg_done), 32'd1);
    check("run_busy", 32'(bus.busy), 32'd0);
    check("load_shift_count", 32'(shift_pulses - base), 32'd4);
    tick();
    check("cfg_done_one_cycle", 32'(bus.cfg_done), 32'd0);
    check("data_in_idle_zero", bus.core_data_in, 32'd0);

    // Impulse response.
    for (int k = 0; k < 5; k++) send_sample(samp[k], expv[k]);
    check("sample_cnt_5", 32'(bus.sample_cnt), 32'd5);

    // Result held under backpressure; a sample offered meanwhile must not reach the core.
    check("run_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd7;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    base = sample_pulses;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd99;
    for (int k = 0; k < 10; k++) begin
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out_data", bus.out_data, 32'd28);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    check("hold_no_core_sample", 32'(sample_pulses - base), 32'd0);
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("sample_cnt_6", 32'(bus.sample_cnt), 32'd6);

    // cfg_start coincident with a sample: sample wins.
    bus.cfg_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd0;
    tick();
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    check("tie_no_load", 32'(bus.cfg_coeff_ready), 32'd0);
    check("tie_busy", 32'(bus.busy), 32'd1);
    check("tie_sample_cnt", 32'(bus.sample_cnt), 32'd7);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("wait_ignores_start", 32'(bus.cfg_coeff_ready), 32'd0);
    tick();
    check("wait_result_valid", 32'(bus.out_valid), 32'd1);
    check("wait_result_data", bus.out_data, 32'd21);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("back_in_run", 32'(bus.in_ready), 32'd1);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("reload_coeff_ready", 32'(bus.cfg_coeff_ready), 32'd1);
    check("reload_sample_cnt", 32'(bus.sample_cnt), 32'd0);
    check("reload_busy", 32'(bus.busy), 32'd1);
    check("strobes_never_both", 32'(both_pulses), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
